// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment capture path:
// glyph encodings, active-low digit selects and FSM states.
package seven_seg_pkg;

    localparam logic [6:0] GLYPH_0 = 7'b0111111;
    localparam logic [6:0] GLYPH_1 = 7'b0000110;
    localparam logic [6:0] GLYPH_2 = 7'b1011011;
    localparam logic [6:0] GLYPH_3 = 7'b1001111;
    localparam logic [6:0] GLYPH_4 = 7'b1100110;
    localparam logic [6:0] GLYPH_5 = 7'b1101101;
    localparam logic [6:0] GLYPH_6 = 7'b1111101;
    localparam logic [6:0] GLYPH_7 = 7'b0000111;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1101111;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b1111100;
    localparam logic [6:0] GLYPH_C = 7'b0111001;
    localparam logic [6:0] GLYPH_D = 7'b1011110;
    localparam logic [6:0] GLYPH_E = 7'b1111001;
    localparam logic [6:0] GLYPH_F = 7'b1110001;

    localparam logic [3:0] SEL_D3    = 4'b0111;
    localparam logic [3:0] SEL_D2    = 4'b1011;
    localparam logic [3:0] SEL_D1    = 4'b1101;
    localparam logic [3:0] SEL_D0    = 4'b1110;
    localparam logic [3:0] SEL_BLANK = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCKED,
        ST_LOST
    } state_t;

endpackage

// File: rtl/seg_to_hex.sv
// Inverse of the display encoder: segment pattern {g..a} to nibble.
// Anything outside the 16 hex glyphs is flagged invalid.
module seg_to_hex
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       valid
);

    always_comb begin
        hex   = 4'h0;
        valid = 1'b1;
        case (seg)
            GLYPH_0: hex = 4'h0;
            GLYPH_1: hex = 4'h1;
            GLYPH_2: hex = 4'h2;
            GLYPH_3: hex = 4'h3;
            GLYPH_4: hex = 4'h4;
            GLYPH_5: hex = 4'h5;
            GLYPH_6: hex = 4'h6;
            GLYPH_7: hex = 4'h7;
            GLYPH_8: hex = 4'h8;
            GLYPH_9: hex = 4'h9;
            GLYPH_A: hex = 4'hA;
            GLYPH_B: hex = 4'hB;
            GLYPH_C: hex = 4'hC;
            GLYPH_D: hex = 4'hD;
            GLYPH_E: hex = 4'hE;
            GLYPH_F: hex = 4'hF;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed 4-digit seven-segment display back into a
// 16-bit frame, with refresh filtering and loss-of-frame detection.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT_W     = 19
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  digit_sel_in,
    output logic [15:0] digits_out,
    output logic        digits_valid,
    output logic        err_seg,
    output logic        err_sel,
    output logic        frame_lost
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);

    logic [3:0]           sel_s1, sel_s2;
    logic [6:0]           seg_s1, seg_s2;
    logic [10:0]          cur, prev;
    logic [RUN_W-1:0]     run_cnt;
    logic                 done;
    logic                 same, accept;
    logic                 onehot, blank, glyph_ok;
    logic [1:0]           pos;
    logic [3:0]           hex;
    logic [3:0]           mask;
    logic [15:0]          shadow;
    logic [TIMEOUT_W-1:0] idle_cnt;
    logic                 idle_sat, frame_done, enter_lost;
    state_t               state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_s1 <= SEL_BLANK;
            sel_s2 <= SEL_BLANK;
            seg_s1 <= '0;
            seg_s2 <= '0;
        end else begin
            sel_s1 <= digit_sel_in;
            sel_s2 <= sel_s1;
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
        end
    end

    assign cur    = {sel_s2, seg_s2};
    assign same   = (cur == prev);
    // run_cnt counts repeat comparisons, so the value has been present
    // STABLE_CYCLES cycles when it reaches STABLE_CYCLES-2 with same set
    assign accept = same && !done && (run_cnt == RUN_W'(STABLE_CYCLES - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev    <= {SEL_BLANK, 7'h00};
            run_cnt <= '0;
            done    <= 1'b0;
        end else begin
            prev <= cur;
            if (!same) begin
                run_cnt <= '0;
                done    <= 1'b0;
            end else if (accept) begin
                done <= 1'b1;
            end else if (!done) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        onehot = 1'b1;
        pos    = 2'd0;
        case (sel_s2)
            SEL_D0:  pos = 2'd0;
            SEL_D1:  pos = 2'd1;
            SEL_D2:  pos = 2'd2;
            SEL_D3:  pos = 2'd3;
            default: onehot = 1'b0;
        endcase
    end

    assign blank = (sel_s2 == SEL_BLANK);

    seg_to_hex u_dec (
        .seg   (seg_s2),
        .hex   (hex),
        .valid (glyph_ok)
    );

    assign frame_done = (mask == 4'hF);
    assign idle_sat   = &idle_cnt;
    assign enter_lost = (state_q == ST_LOCKED) && (state_d == ST_LOST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_out   <= '0;
            digits_valid <= 1'b0;
            err_seg      <= 1'b0;
            err_sel      <= 1'b0;
            mask         <= '0;
            shadow       <= '0;
            idle_cnt     <= '0;
        end else begin
            digits_valid <= frame_done;
            err_seg      <= accept && onehot && !glyph_ok;
            err_sel      <= accept && !onehot && !blank;
            if (frame_done)
                digits_out <= shadow;
            if (accept && onehot && glyph_ok)
                shadow[{pos, 2'b00} +: 4] <= hex;
            if (frame_done || enter_lost)
                mask <= '0;
            else if (accept && onehot)
                mask[pos] <= glyph_ok;
            if (accept)
                idle_cnt <= '0;
            else if (!idle_sat)
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // an accept in the saturating cycle wins over the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (frame_done) state_d = ST_LOCKED;
            ST_LOCKED: if (idle_sat && !accept) state_d = ST_LOST;
            ST_LOST:   if (frame_done) state_d = ST_LOCKED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_lost = (state_q == ST_LOST);
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: reset, loopback, glitch,
// bad glyph, bad select and frame-loss timeout.
module tb_seven_seg_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg_in;
    logic [3:0]  digit_sel_in;
    logic [15:0] digits_out;
    logic        digits_valid;
    logic        err_seg;
    logic        err_sel;
    logic        frame_lost;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    int nv  = 0;
    int nes = 0;
    int nsl = 0;
    int nvl = 0;
    logic prev_lost = 1'b0;
    logic lost_before_valid = 1'b0;

    seven_seg_capture #(
        .STABLE_CYCLES (4),
        .TIMEOUT_W     (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .seg_in       (seg_in),
        .digit_sel_in (digit_sel_in),
        .digits_out   (digits_out),
        .digits_valid (digits_valid),
        .err_seg      (err_seg),
        .err_sel      (err_sel),
        .frame_lost   (frame_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (digits_valid) begin
                nv++;
                lost_before_valid = prev_lost;
                if (frame_lost) nvl++;
            end
            if (err_seg) nes++;
            if (err_sel) nsl++;
            prev_lost = frame_lost;
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1101111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            default: glyph = 7'b1110001;
        endcase
    endfunction

    function automatic logic [3:0] sel_of(input int p);
        logic [3:0] one;
        one = 4'b0001;
        sel_of = ~(one << p);
    endfunction

    task automatic hold(input logic [3:0] s, input logic [6:0] g, input int n);
        digit_sel_in = s;
        seg_in       = g;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_digit(input int p, input logic [3:0] h);
        hold(sel_of(p), glyph(h), 8);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        digit_sel_in = 4'hF;
        seg_in = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (digits_out !== 16'h0) $display("FAIL reset_digits got %h want 0000", digits_out);
        else pass_cnt++;
        chk_cnt++;
        if ({digits_valid, err_seg, err_sel, frame_lost} !== 4'b0)
            $display("FAIL reset_flags got %b want 0000",
                     {digits_valid, err_seg, err_sel, frame_lost});
        else pass_cnt++;
        reset = 1'b0;
        hold(4'hF, 7'h00, 300);
        chk_cnt++;
        if (frame_lost !== 1'b0) $display("FAIL idle_no_lost got %b want 0", frame_lost);
        else pass_cnt++;
    endtask

    task automatic test_loopback;
        int b0, b1, b2;
        logic [15:0] val;
        val = 16'hA5C3;
        b0 = nv; b1 = nes; b2 = nsl;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++)
                hold(sel_of(p), glyph(val[p*4 +: 4]), 16);
        chk_cnt++;
        if (digits_out !== 16'hA5C3) $display("FAIL loop_data got %h want a5c3", digits_out);
        else pass_cnt++;
        chk_cnt++;
        if (nv - b0 !== 2) $display("FAIL loop_valid_cnt got %0d want 2", nv - b0);
        else pass_cnt++;
        chk_cnt++;
        if ((nes - b1) + (nsl - b2) !== 0)
            $display("FAIL loop_errs got %0d want 0", (nes - b1) + (nsl - b2));
        else pass_cnt++;
        chk_cnt++;
        if (frame_lost !== 1'b0) $display("FAIL loop_lost got %b want 0", frame_lost);
        else pass_cnt++;
    endtask

    task automatic test_glitch;
        int b0, b1, b2;
        hold(4'hF, 7'h00, 8);
        send_digit(0, 4'h3);
        b0 = nv; b1 = nes; b2 = nsl;
        hold(sel_of(1), glyph(4'h3), 2);
        hold(sel_of(0), glyph(4'h3), 10);
        send_digit(2, 4'h5);
        send_digit(3, 4'hA);
        chk_cnt++;
        if (nv - b0 !== 0) $display("FAIL glitch_no_frame got %0d want 0", nv - b0);
        else pass_cnt++;
        chk_cnt++;
        if ((nes - b1) + (nsl - b2) !== 0)
            $display("FAIL glitch_errs got %0d want 0", (nes - b1) + (nsl - b2));
        else pass_cnt++;
        send_digit(1, 4'hC);
        chk_cnt++;
        if (nv - b0 !== 1) $display("FAIL glitch_frame got %0d want 1", nv - b0);
        else pass_cnt++;
        chk_cnt++;
        if (digits_out !== 16'hA5C3) $display("FAIL glitch_data got %h want a5c3", digits_out);
        else pass_cnt++;
    endtask

    task automatic test_bad_glyph;
        int b0, b1;
        b0 = nv; b1 = nes;
        send_digit(0, 4'h1);
        send_digit(2, 4'h2);
        send_digit(3, 4'h4);
        hold(sel_of(1), 7'b0000001, 20);
        chk_cnt++;
        if (nes - b1 !== 1) $display("FAIL badglyph_err got %0d want 1", nes - b1);
        else pass_cnt++;
        chk_cnt++;
        if (nv - b0 !== 0) $display("FAIL badglyph_noframe got %0d want 0", nv - b0);
        else pass_cnt++;
        hold(sel_of(1), 7'b1101101, 8);
        chk_cnt++;
        if (nv - b0 !== 1) $display("FAIL badglyph_frame got %0d want 1", nv - b0);
        else pass_cnt++;
        chk_cnt++;
        if (digits_out[7:4] !== 4'h5) $display("FAIL badglyph_d1 got %h want 5", digits_out[7:4]);
        else pass_cnt++;
        chk_cnt++;
        if (digits_out !== 16'h4251) $display("FAIL badglyph_data got %h want 4251", digits_out);
        else pass_cnt++;
    endtask

    task automatic test_bad_select;
        int b1, b2;
        b1 = nes; b2 = nsl;
        hold(4'b0011, glyph(4'h8), 100);
        chk_cnt++;
        if (nsl - b2 !== 1) $display("FAIL badsel_err got %0d want 1", nsl - b2);
        else pass_cnt++;
        chk_cnt++;
        if (nes - b1 !== 0) $display("FAIL badsel_segerr got %0d want 0", nes - b1);
        else pass_cnt++;
        b2 = nsl;
        hold(4'b1111, glyph(4'h8), 20);
        chk_cnt++;
        if (nsl - b2 !== 0) $display("FAIL blank_err got %0d want 0", nsl - b2);
        else pass_cnt++;
    endtask

    task automatic test_timeout;
        int b0, n;
        b0 = nv;
        for (int p = 0; p < 4; p++) send_digit(p, 4'(p + 1));
        chk_cnt++;
        if (digits_out !== 16'h4321) $display("FAIL to_frame got %h want 4321", digits_out);
        else pass_cnt++;
        send_digit(0, 4'hF);
        send_digit(1, 4'hE);
        digit_sel_in = 4'hF;
        seg_in = 7'h00;
        n = 0;
        while (!frame_lost && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_cnt++;
        if (n < 258 || n > 266) $display("FAIL to_rise got %0d cycles want 258..266", n);
        else pass_cnt++;
        b0 = nv;
        send_digit(2, 4'hE);
        send_digit(3, 4'hB);
        chk_cnt++;
        if (nv - b0 !== 0) $display("FAIL to_mask_clr got %0d want 0", nv - b0);
        else pass_cnt++;
        chk_cnt++;
        if (frame_lost !== 1'b1) $display("FAIL to_still_lost got %b want 1", frame_lost);
        else pass_cnt++;
        send_digit(0, 4'hF);
        send_digit(1, 4'hD);
        chk_cnt++;
        if (nv - b0 !== 1) $display("FAIL to_relock got %0d want 1", nv - b0);
        else pass_cnt++;
        chk_cnt++;
        if (frame_lost !== 1'b0) $display("FAIL to_lost_drop got %b want 0", frame_lost);
        else pass_cnt++;
        chk_cnt++;
        if (lost_before_valid !== 1'b1 || nvl !== 0)
            $display("FAIL to_drop_cycle got prev=%b overlap=%0d want 1/0",
                     lost_before_valid, nvl);
        else pass_cnt++;
        chk_cnt++;
        if (digits_out !== 16'hBEDF) $display("FAIL to_data got %h want bedf", digits_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame;
        int b0;
        send_digit(0, 4'h6);
        send_digit(1, 4'h7);
        send_digit(2, 4'h8);
        digit_sel_in = 4'hF;
        seg_in = 7'h00;
        #3;
        reset = 1'b1;
        #1;
        chk_cnt++;
        if (digits_out !== 16'h0) $display("FAIL rst_async_data got %h want 0000", digits_out);
        else pass_cnt++;
        chk_cnt++;
        if ({digits_valid, err_seg, err_sel, frame_lost} !== 4'b0)
            $display("FAIL rst_async_flags got %b want 0000",
                     {digits_valid, err_seg, err_sel, frame_lost});
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        b0 = nv;
        send_digit(3, 4'h9);
        hold(4'hF, 7'h00, 8);
        chk_cnt++;
        if (nv - b0 !== 0) $display("FAIL rst_partial got %0d want 0", nv - b0);
        else pass_cnt++;
        send_digit(0, 4'h6);
        send_digit(1, 4'h7);
        send_digit(2, 4'h8);
        chk_cnt++;
        if (nv - b0 !== 1) $display("FAIL rst_refill got %0d want 1", nv - b0);
        else pass_cnt++;
        chk_cnt++;
        if (digits_out !== 16'h9876) $display("FAIL rst_data got %h want 9876", digits_out);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_loopback;
        test_glitch;
        test_bad_glyph;
        test_bad_select;
        test_timeout;
        test_reset_mid_frame;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
